// File: rtl/ddr_line_buffer.sv
// One-line cache buffer between the line controller and DDR.
// The controller holds an enable high until the matching OK returns. The line moves to and from DDR in ascending beats.
module ddr_line_buffer #(
    parameter int unsigned LINE_W = 4096,
    parameter int unsigned BEAT_W = 128,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [LINE_W-1:0] data_in,
    output logic [LINE_W-1:0] data_out,
    input  logic              we_in,
    input  logic              re_in,
    input  logic              we_to_ddr,
    input  logic              we_from_ddr,
    output logic              write_ok,
    output logic              read_ok,
    output logic              ddr_write_ok,
    output logic              ddr_read_ok,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    output logic              mem_wr_req,
    input  logic              mem_ack,
    output logic              mem_rd_req,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid
);

    localparam int unsigned BEATS      = LINE_W / BEAT_W;
    localparam int unsigned BEAT_CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BEAT_BYTES = BEAT_W / 8;
    localparam int unsigned LINE_BYTES = LINE_W / 8;
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        LOAD_DONE,
        WB,
        WB_DONE,
        FILL,
        FILL_DONE,
        RD,
        RD_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [BEAT_CW-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                write_ok_q, write_ok_d;
    logic                read_ok_q, read_ok_d;
    logic                ddr_write_ok_q, ddr_write_ok_d;
    logic                ddr_read_ok_q, ddr_read_ok_d;
    logic                mem_wr_req_q, mem_wr_req_d;
    logic                mem_rd_req_q, mem_rd_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BEAT_W-1:0]   mem_wdata_q, mem_wdata_d;

    // Next state, line/beat/base updates, and outputs derived from the next state
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        base_d  = base_q;

        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (we_in || we_to_ddr || we_from_ddr || re_in) begin
                    base_d = addr_in & ~ADDR_W'(LINE_BYTES - 1);
                end
                if (we_in) begin
                    state_d = LOAD;
                end else if (we_to_ddr) begin
                    state_d = WB;
                end else if (we_from_ddr) begin
                    state_d = FILL;
                end else if (re_in) begin
                    state_d = RD;
                end
            end
            LOAD: begin
                line_d  = data_in;
                state_d = LOAD_DONE;
            end
            LOAD_DONE: if (!we_in) state_d = IDLE;
            WB: begin
                if (mem_ack) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = WB_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_CW'(1);
                    end
                end
            end
            WB_DONE: if (!we_to_ddr) state_d = IDLE;
            FILL: begin
                if (mem_rdata_valid) begin
                    line_d[BEAT_W*int'(beat_q) +: BEAT_W] = mem_rdata;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = FILL_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_CW'(1);
                    end
                end
            end
            FILL_DONE: if (!we_from_ddr) state_d = IDLE;
            RD:        state_d = RD_DONE;
            RD_DONE:   if (!re_in) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        write_ok_d     = (state_d == LOAD_DONE);
        read_ok_d      = (state_d == RD_DONE);
        ddr_write_ok_d = (state_d == WB_DONE);
        ddr_read_ok_d  = (state_d == FILL_DONE);
        mem_wr_req_d   = (state_d == WB);
        mem_rd_req_d   = (state_d == FILL);
        mem_addr_d     = '0;
        mem_wdata_d    = '0;
        if (state_d == WB || state_d == FILL) begin
            mem_addr_d = base_d + ADDR_W'(beat_d) * ADDR_W'(BEAT_BYTES);
        end
        if (state_d == WB) begin
            mem_wdata_d = line_d[BEAT_W*int'(beat_d) +: BEAT_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            line_q         <= '0;
            beat_q         <= '0;
            base_q         <= '0;
            write_ok_q     <= 1'b0;
            read_ok_q      <= 1'b0;
            ddr_write_ok_q <= 1'b0;
            ddr_read_ok_q  <= 1'b0;
            mem_wr_req_q   <= 1'b0;
            mem_rd_req_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            line_q         <= line_d;
            beat_q         <= beat_d;
            base_q         <= base_d;
            write_ok_q     <= write_ok_d;
            read_ok_q      <= read_ok_d;
            ddr_write_ok_q <= ddr_write_ok_d;
            ddr_read_ok_q  <= ddr_read_ok_d;
            mem_wr_req_q   <= mem_wr_req_d;
            mem_rd_req_q   <= mem_rd_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
        end
    end

    assign data_out     = line_q;
    assign write_ok     = write_ok_q;
    assign read_ok      = read_ok_q;
    assign ddr_write_ok = ddr_write_ok_q;
    assign ddr_read_ok  = ddr_read_ok_q;
    assign mem_wr_req   = mem_wr_req_q;
    assign mem_rd_req   = mem_rd_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_ddr_line_buffer.sv
// Bench for ddr_line_buffer: random lines and memory timing checked against a word-array model of the line.
// Expected beat addresses and beat data come from plain arithmetic on that model.
module tb_ddr_line_buffer;

    localparam int unsigned LINE_W = 4096;
    localparam int unsigned BEAT_W = 128;
    localparam int unsigned ADDR_W = 32;
    localparam int BEATS = 32;
    localparam int WORDS = 128;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] addr_in = '0;
    logic [LINE_W-1:0] data_in = '0;
    logic [LINE_W-1:0] data_out;
    logic              we_in = 1'b0, re_in = 1'b0, we_to_ddr = 1'b0, we_from_ddr = 1'b0;
    logic              write_ok, read_ok, ddr_write_ok, ddr_read_ok;
    logic [ADDR_W-1:0] mem_addr;
    logic [BEAT_W-1:0] mem_wdata;
    logic              mem_wr_req, mem_rd_req;
    logic              mem_ack = 1'b0;
    logic [BEAT_W-1:0] mem_rdata = '0;
    logic              mem_rdata_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] ref_words [WORDS];

    always #5 clk = ~clk;

    ddr_line_buffer dut (
        .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .data_out(data_out),
        .we_in(we_in), .re_in(re_in), .we_to_ddr(we_to_ddr), .we_from_ddr(we_from_ddr),
        .write_ok(write_ok), .read_ok(read_ok), .ddr_write_ok(ddr_write_ok), .ddr_read_ok(ddr_read_ok),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_req(mem_wr_req), .mem_ack(mem_ack),
        .mem_rd_req(mem_rd_req), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
    );

    function automatic logic [LINE_W-1:0] ref_line();
        logic [LINE_W-1:0] l;
        for (int k = 0; k < WORDS; k++) l[k*32 +: 32] = ref_words[k];
        return l;
    endfunction

    function automatic logic [BEAT_W-1:0] ref_beat(int i);
        logic [BEAT_W-1:0] b;
        for (int j = 0; j < 4; j++) b[j*32 +: 32] = ref_words[i*4 + j];
        return b;
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(logic [ADDR_W-1:0] a);
        return (a / 512) * 512;
    endfunction

    function automatic int first_diff(logic [LINE_W-1:0] a, logic [LINE_W-1:0] b);
        for (int k = 0; k < WORDS; k++) if (a[k*32 +: 32] !== b[k*32 +: 32]) return k;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [LINE_W-1:0] exp_line;
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < WORDS; k++) ref_words[k] = '0;
        exp_line = ref_line();
        n_checks++;
        if ({write_ok, read_ok, ddr_write_ok, ddr_read_ok, mem_wr_req, mem_rd_req, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ok=%b%b%b%b req=%b%b addr=%h wdata=%h want all 0",
                     write_ok, read_ok, ddr_write_ok, ddr_read_ok, mem_wr_req, mem_rd_req, mem_addr, mem_wdata);
        end
        n_checks++;
        if (data_out !== exp_line) begin
            n_fail++;
            $display("FAIL reset_data_out: first bad word %0d want 0", first_diff(data_out, exp_line));
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_load(input bit counting);
        logic [LINE_W-1:0] exp_line;
        for (int k = 0; k < WORDS; k++) ref_words[k] = counting ? 32'(k) : $urandom;
        exp_line = ref_line();
        data_in  = exp_line;
        we_in    = 1'b1;
        step();
        n_checks++;
        if (write_ok !== 1'b0) begin n_fail++; $display("FAIL load_early: write_ok=%b want 0", write_ok); end
        step();
        n_checks++;
        if (write_ok !== 1'b1) begin n_fail++; $display("FAIL load_ok: write_ok=%b want 1", write_ok); end
        n_checks++;
        if (data_out !== exp_line) begin
            n_fail++;
            $display("FAIL load_data: first bad word %0d", first_diff(data_out, exp_line));
        end
        data_in = {WORDS{$urandom}};
        step();
        n_checks++;
        if (write_ok !== 1'b1 || data_out !== exp_line) begin
            n_fail++;
            $display("FAIL load_hold: write_ok=%b want 1, bad word %0d", write_ok, first_diff(data_out, exp_line));
        end
        we_in = 1'b0;
        step();
        n_checks++;
        if ({write_ok, mem_wr_req, mem_rd_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_release: write_ok/wr_req/rd_req=%b want 000", {write_ok, mem_wr_req, mem_rd_req});
        end
    endtask

    task automatic test_writeback(input logic [ADDR_W-1:0] a, input int period, input bit also_fill);
        logic [ADDR_W-1:0] base;
        int accepted = 0;
        int cyc = 0;
        bit ack;
        base        = base_of(a);
        addr_in     = a;
        we_to_ddr   = 1'b1;
        we_from_ddr = also_fill;
        step();
        while (accepted < BEATS && cyc < 2000) begin
            n_checks++;
            if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0) begin
                n_fail++;
                $display("FAIL wb_req beat %0d: wr=%b rd=%b want 1 0", accepted, mem_wr_req, mem_rd_req);
            end
            n_checks++;
            if (mem_addr !== base + 32'(accepted * 16)) begin
                n_fail++;
                $display("FAIL wb_addr beat %0d: got %h want %h", accepted, mem_addr, base + 32'(accepted * 16));
            end
            n_checks++;
            if (mem_wdata !== ref_beat(accepted)) begin
                n_fail++;
                $display("FAIL wb_data beat %0d: got %h want %h", accepted, mem_wdata, ref_beat(accepted));
            end
            n_checks++;
            if (ddr_write_ok !== 1'b0) begin
                n_fail++;
                $display("FAIL wb_early_ok beat %0d: ddr_write_ok=%b want 0", accepted, ddr_write_ok);
            end
            ack     = ((cyc % period) == period - 1);
            mem_ack = ack;
            addr_in = $urandom;
            step();
            mem_ack = 1'b0;
            if (ack) accepted++;
            cyc++;
        end
        n_checks++;
        if (accepted != BEATS) begin n_fail++; $display("FAIL wb_timeout: %0d beats want %0d", accepted, BEATS); end
        n_checks++;
        if ({ddr_write_ok, mem_wr_req} !== 2'b10 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL wb_done: ok=%b req=%b addr=%h want ok=1 req=0 addr=0", ddr_write_ok, mem_wr_req, mem_addr);
        end
        we_to_ddr   = 1'b0;
        we_from_ddr = 1'b0;
        step();
        n_checks++;
        if (ddr_write_ok !== 1'b0 || data_out !== ref_line()) begin
            n_fail++;
            $display("FAIL wb_release: ddr_write_ok=%b want 0, bad word %0d", ddr_write_ok, first_diff(data_out, ref_line()));
        end
    endtask

    task automatic test_fill(input logic [ADDR_W-1:0] a, input bit rand_mode, input int drop_at);
        logic [ADDR_W-1:0] base;
        logic [BEAT_W-1:0] d;
        int got = 0;
        int cyc = 0;
        bit v;
        // stray read data while idle must not touch the line
        mem_rdata_valid = 1'b1;
        mem_rdata       = {$urandom, $urandom, $urandom, $urandom};
        step();
        step();
        mem_rdata_valid = 1'b0;
        n_checks++;
        if (data_out !== ref_line()) begin
            n_fail++;
            $display("FAIL fill_stray_valid: bad word %0d", first_diff(data_out, ref_line()));
        end
        base        = base_of(a);
        addr_in     = a;
        we_from_ddr = 1'b1;
        step();
        while (got < BEATS && cyc < 2000) begin
            n_checks++;
            if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0 || ddr_read_ok !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_req beat %0d: rd=%b wr=%b ok=%b want 1 0 0", got, mem_rd_req, mem_wr_req, ddr_read_ok);
            end
            n_checks++;
            if (mem_addr !== base + 32'(got * 16)) begin
                n_fail++;
                $display("FAIL fill_addr beat %0d: got %h want %h", got, mem_addr, base + 32'(got * 16));
            end
            v = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            d = rand_mode ? {$urandom, $urandom, $urandom, $urandom} : {4{32'(got)}};
            mem_rdata_valid = v;
            mem_rdata       = d;
            step();
            mem_rdata_valid = 1'b0;
            if (v) begin
                for (int j = 0; j < 4; j++) ref_words[got*4 + j] = d[j*32 +: 32];
                got++;
                if (got == drop_at) we_from_ddr = 1'b0;
            end
            cyc++;
        end
        n_checks++;
        if (got != BEATS) begin n_fail++; $display("FAIL fill_timeout: %0d beats want %0d", got, BEATS); end
        n_checks++;
        if ({ddr_read_ok, mem_rd_req} !== 2'b10 || mem_addr !== '0) begin
            n_fail++;
            $display("FAIL fill_done: ok=%b req=%b addr=%h want ok=1 req=0 addr=0", ddr_read_ok, mem_rd_req, mem_addr);
        end
        n_checks++;
        if (data_out !== ref_line()) begin
            n_fail++;
            $display("FAIL fill_data: first bad word %0d", first_diff(data_out, ref_line()));
        end
        if (we_from_ddr) begin
            step();
            n_checks++;
            if (ddr_read_ok !== 1'b1) begin n_fail++; $display("FAIL fill_hold: ddr_read_ok=%b want 1", ddr_read_ok); end
            we_from_ddr = 1'b0;
        end
        step();
        n_checks++;
        if (ddr_read_ok !== 1'b0) begin n_fail++; $display("FAIL fill_release: ddr_read_ok=%b want 0", ddr_read_ok); end
    endtask

    task automatic test_read();
        re_in = 1'b1;
        step();
        n_checks++;
        if (read_ok !== 1'b0) begin n_fail++; $display("FAIL read_early: read_ok=%b want 0", read_ok); end
        step();
        n_checks++;
        if (read_ok !== 1'b1 || data_out !== ref_line()) begin
            n_fail++;
            $display("FAIL read_ok: read_ok=%b want 1, bad word %0d", read_ok, first_diff(data_out, ref_line()));
        end
        data_in         = {WORDS{$urandom}};
        mem_rdata_valid = 1'b1;
        mem_rdata       = {$urandom, $urandom, $urandom, $urandom};
        step();
        mem_rdata_valid = 1'b0;
        n_checks++;
        if (read_ok !== 1'b1 || data_out !== ref_line()) begin
            n_fail++;
            $display("FAIL read_frozen: read_ok=%b want 1, bad word %0d", read_ok, first_diff(data_out, ref_line()));
        end
        re_in = 1'b0;
        step();
        n_checks++;
        if (read_ok !== 1'b0) begin n_fail++; $display("FAIL read_release: read_ok=%b want 0", read_ok); end
    endtask

    task automatic test_priority();
        for (int k = 0; k < WORDS; k++) ref_words[k] = $urandom;
        data_in = ref_line();
        we_in   = 1'b1;
        re_in   = 1'b1;
        step();
        step();
        n_checks++;
        if ({write_ok, read_ok} !== 2'b10 || data_out !== ref_line()) begin
            n_fail++;
            $display("FAIL prio_load_over_read: write_ok/read_ok=%b want 10, bad word %0d",
                     {write_ok, read_ok}, first_diff(data_out, ref_line()));
        end
        we_in = 1'b0;
        re_in = 1'b0;
        step();
        n_checks++;
        if ({write_ok, read_ok} !== 2'b00) begin
            n_fail++;
            $display("FAIL prio_release: write_ok/read_ok=%b want 00", {write_ok, read_ok});
        end
        // we_in dropped during LOAD still completes with a one-cycle OK
        for (int k = 0; k < WORDS; k++) ref_words[k] = $urandom;
        data_in = ref_line();
        we_in   = 1'b1;
        step();
        we_in = 1'b0;
        step();
        n_checks++;
        if (write_ok !== 1'b1 || data_out !== ref_line()) begin
            n_fail++;
            $display("FAIL load_abort_pulse: write_ok=%b want 1, bad word %0d", write_ok, first_diff(data_out, ref_line()));
        end
        step();
        n_checks++;
        if (write_ok !== 1'b0) begin n_fail++; $display("FAIL load_abort_end: write_ok=%b want 0", write_ok); end
    endtask

    task automatic test_reset_mid_fill(input logic [ADDR_W-1:0] a);
        int got = 0;
        addr_in     = a;
        we_from_ddr = 1'b1;
        step();
        while (got < 7) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = {$urandom, $urandom, $urandom, $urandom};
            step();
            got++;
        end
        mem_rdata_valid = 1'b1;
        mem_ack         = 1'b1;
        reset           = 1'b1;
        #1;
        for (int k = 0; k < WORDS; k++) ref_words[k] = '0;
        n_checks++;
        if ({write_ok, read_ok, ddr_write_ok, ddr_read_ok, mem_wr_req, mem_rd_req, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL midfill_reset_outputs: rd_req=%b addr=%h ok=%b want all 0", mem_rd_req, mem_addr, ddr_read_ok);
        end
        n_checks++;
        if (data_out !== ref_line()) begin
            n_fail++;
            $display("FAIL midfill_reset_data: first bad word %0d want 0", first_diff(data_out, ref_line()));
        end
        we_from_ddr     = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_ack         = 1'b0;
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if ({ddr_read_ok, mem_rd_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL midfill_no_ok: ok/rd_req=%b want 00", {ddr_read_ok, mem_rd_req});
        end
    endtask

    initial begin
        test_reset();
        test_load(1'b1);
        test_writeback(32'h0000_1234, 1, 1'b0);
        test_load(1'b0);
        test_writeback($urandom, 3, 1'b0);
        test_fill($urandom, 1'b0, -1);
        test_read();
        test_priority();
        test_writeback($urandom, 2, 1'b1);
        test_fill($urandom, 1'b1, 10);
        test_read();
        test_reset_mid_fill($urandom);
        test_fill($urandom, 1'b0, -1);
        test_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
